// File: rtl/ad9911_pkg.sv
// Shared constants and types for the AD9911 configuration sequencer:
// register map, table indices, FSM encoding and the write payload.
package ad9911_pkg;

  localparam int unsigned FTW_W    = 32;
  localparam int unsigned POW_W    = 14;
  localparam int unsigned AMP_W    = 10;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 5;
  localparam int unsigned IDX_W    = 3;

  localparam logic [ADDR_W-1:0] ADDR_CSR   = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_CFR   = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_CTW0  = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_CPOW0 = 8'h05;
  localparam logic [ADDR_W-1:0] ADDR_ACR   = 8'h06;

  localparam logic [IDX_W-1:0] IDX_CSR   = 3'd0;
  localparam logic [IDX_W-1:0] IDX_CFR   = 3'd1;
  localparam logic [IDX_W-1:0] IDX_CTW0  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_CPOW0 = 3'd3;
  localparam logic [IDX_W-1:0] IDX_ACR   = 3'd4;

  // ACR amplitude multiplier enable
  localparam int unsigned ACR_MULT_EN_BIT = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PICK = 3'd2,
    ST_REQ  = 3'd3,
    ST_WAIT = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_wr_t;

endpackage

// File: rtl/ad9911_cfg_sequencer_if.sv
// Single-register write handshake between the sequencer and the SPI writer.
interface ad9911_cfg_sequencer_if;
  import ad9911_pkg::*;

  logic              SPI_TR;
  logic [ADDR_W-1:0] SPI_ADDR;
  logic [DATA_W-1:0] SPI_DATA;
  logic              SPI_BUSY;

  modport master (output SPI_TR, output SPI_ADDR, output SPI_DATA, input SPI_BUSY);
  modport slave  (input SPI_TR, input SPI_ADDR, input SPI_DATA, output SPI_BUSY);
endinterface

// File: rtl/ad9911_cfg_sequencer.sv
// Turns one tuning request into an ordered series of AD9911 register writes,
// skipping registers whose shadow copy already matches.
module ad9911_cfg_sequencer
  import ad9911_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter logic [31:0] CFR_VALUE   = 32'h0000_0300,
  parameter logic [31:0] CSR_VALUE   = 32'h0000_0010
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic                   FORCE,
  input  logic [FTW_W-1:0]       FTW,
  input  logic [POW_W-1:0]       POW,
  input  logic [AMP_W-1:0]       AMP,
  ad9911_cfg_sequencer_if.master spi,
  output logic                   READY,
  output logic                   DONE,
  output logic                   ERR
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC);

  state_t              state;
  logic                tr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic [FTW_W-1:0]    ftw_l, ftw_s;
  logic [POW_W-1:0]    pow_l, pow_s;
  logic [AMP_W-1:0]    amp_l, amp_s;
  logic                force_l;
  logic                valid_s;
  logic [NUM_REGS-1:0] dirty;
  logic [TIMER_W-1:0]  timer;
  spi_wr_t             entry_c;
  logic                timeout_c;

  // Lowest set bit of the dirty mask selects the next register to write
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] d);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (d[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic spi_wr_t reg_entry(input logic [IDX_W-1:0] idx,
                                        input logic [FTW_W-1:0] ftw,
                                        input logic [POW_W-1:0] pow,
                                        input logic [AMP_W-1:0] amp);
    spi_wr_t e;
    e = '0;
    case (idx)
      IDX_CSR:   begin e.addr = ADDR_CSR;   e.data = {24'b0, CSR_VALUE[7:0]}; end
      IDX_CFR:   begin e.addr = ADDR_CFR;   e.data = {8'b0, CFR_VALUE[23:0]}; end
      IDX_CTW0:  begin e.addr = ADDR_CTW0;  e.data = ftw; end
      IDX_CPOW0: begin e.addr = ADDR_CPOW0; e.data = DATA_W'(pow); end
      IDX_ACR:   begin
        e.addr = ADDR_ACR;
        e.data = DATA_W'(amp) | (DATA_W'(1) << ACR_MULT_EN_BIT);
      end
      default:   e = '0;
    endcase
    return e;
  endfunction

  assign entry_c   = reg_entry(lowest_idx(dirty), ftw_l, pow_l, amp_l);
  assign timeout_c = (timer == TIMER_MAX);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      tr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ftw_l   <= '0;
      pow_l   <= '0;
      amp_l   <= '0;
      force_l <= 1'b0;
      ftw_s   <= '0;
      pow_s   <= '0;
      amp_s   <= '0;
      valid_s <= 1'b0;
      dirty   <= '0;
      timer   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            ftw_l   <= FTW;
            pow_l   <= POW;
            amp_l   <= AMP;
            force_l <= FORCE;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!valid_s || force_l) dirty <= '1;
          else dirty <= {amp_l != amp_s, pow_l != pow_s, ftw_l != ftw_s, 2'b00};
          state <= ST_PICK;
        end
        ST_PICK: begin
          if (dirty == '0) begin
            done_q <= 1'b1;
            state  <= ST_FIN;
          end else begin
            addr_q <= entry_c.addr;
            data_q <= entry_c.data;
            timer  <= '0;
            tr_q   <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (spi.SPI_BUSY) begin
            tr_q  <= 1'b0;
            dirty <= dirty & (dirty - NUM_REGS'(1));  // drop lowest set bit
            timer <= '0;
            state <= ST_WAIT;
          end else if (timeout_c) begin
            err_q  <= 1'b1;
            tr_q   <= 1'b0;
            dirty  <= '0;
            done_q <= 1'b1;
            state  <= ST_FIN;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_WAIT: begin
          if (!spi.SPI_BUSY) begin
            state <= ST_PICK;
          end else if (timeout_c) begin
            err_q  <= 1'b1;
            dirty  <= '0;
            done_q <= 1'b1;
            state  <= ST_FIN;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_FIN: begin
          // An aborted request leaves the shadows untouched
          if (!err_q) begin
            ftw_s   <= ftw_l;
            pow_s   <= pow_l;
            amp_s   <= amp_l;
            valid_s <= 1'b1;
          end
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          tr_q    <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi.SPI_TR   = tr_q;
  assign spi.SPI_ADDR = addr_q;
  assign spi.SPI_DATA = data_q;
  assign READY        = ready_q;
  assign DONE         = done_q;
  assign ERR          = err_q;

endmodule

// File: tb/tb_ad9911_cfg_sequencer.sv
// Scoreboard bench for ad9911_cfg_sequencer: stimulus queues expected writes
// and DONE events, a negedge monitor pops and compares them as they appear.
module tb_ad9911_cfg_sequencer;

  localparam int unsigned TO = 1023;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic        FORCE;
  logic [31:0] FTW;
  logic [13:0] POW;
  logic [9:0]  AMP;
  logic        READY;
  logic        DONE;
  logic        ERR;

  ad9911_cfg_sequencer_if spi ();

  ad9911_cfg_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .FORCE   (FORCE),
    .FTW     (FTW),
    .POW     (POW),
    .AMP     (AMP),
    .spi     (spi),
    .READY   (READY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   ctw_cnt = 0;
  int   start_cyc = 0;
  bit   bfm_en = 1'b1;
  logic prev_tr = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Writer model: accept TR, raise BUSY after 2 cycles for 6 cycles
  initial begin
    spi.SPI_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (bfm_en && RESET_N && spi.SPI_TR && !spi.SPI_BUSY) begin
        repeat (2) @(negedge CLK);
        spi.SPI_BUSY = 1'b1;
        repeat (6) @(negedge CLK);
        spi.SPI_BUSY = 1'b0;
      end
    end
  end

  // Monitor: every TR rise is a presented write; every DONE is a completion
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        prev_tr = 1'b0;
      end else begin
        if (spi.SPI_TR && !prev_tr) begin
          chk("tr_rise_while_busy", 64'(spi.SPI_BUSY), 64'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(spi.SPI_ADDR), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_write", 64'(e.is_done), 64'd0);
            chk("spi_addr", 64'(spi.SPI_ADDR), 64'(e.addr));
            chk("spi_data", 64'(spi.SPI_DATA), 64'(e.data));
          end
          if (spi.SPI_ADDR == 8'h04) ctw_cnt++;
        end
        if (DONE) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("event_kind_done", 64'(e.is_done), 64'd1);
            chk("err_at_done", 64'(ERR), 64'(e.err));
          end
          done_cnt++;
          done_cyc = cyc;
        end
        prev_tr = spi.SPI_TR;
      end
    end
  end

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic err);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic push_full(input logic [31:0] f, input logic [13:0] p, input logic [9:0] a);
    push_wr(8'h00, 32'h0000_0010);
    push_wr(8'h03, 32'h0000_0300);
    push_wr(8'h04, f);
    push_wr(8'h05, {18'b0, p});
    push_wr(8'h06, 32'h0000_1000 | {22'b0, a});
  endtask

  task automatic issue(input logic [31:0] f, input logic [13:0] p, input logic [9:0] a,
                       input logic frc);
    int n;
    n = 0;
    @(negedge CLK);
    while (!READY && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_before_start", 64'(READY), 64'd1);
    FTW = f; POW = p; AMP = a; FORCE = frc;
    START = 1'b1;
    start_cyc = cyc;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n;
    n = 0;
    while (done_cnt < target && n < bound) begin
      @(negedge CLK);
      n++;
    end
    chk("done_seen", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tr",    64'(spi.SPI_TR),   64'd0);
    chk("rst_addr",  64'(spi.SPI_ADDR), 64'd0);
    chk("rst_data",  64'(spi.SPI_DATA), 64'd0);
    chk("rst_ready", 64'(READY),        64'd1);
    chk("rst_done",  64'(DONE),         64'd0);
    chk("rst_err",   64'(ERR),          64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (12) @(negedge CLK);
  endtask

  initial begin
    int tgt;
    int n;
    int lat;
    RESET_N = 1'b0; START = 1'b0; FORCE = 1'b0;
    FTW = '0; POW = '0; AMP = '0;
    repeat (3) @(negedge CLK);
    chk_reset_outputs();
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // First request after reset: full five-register write
    push_full(32'h1999_999A, 14'h0400, 10'h3FF);
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'h1999_999A, 14'h0400, 10'h3FF, 1'b0);
    wait_done(tgt, 400);

    // Only FTW changed: single CTW0 write
    push_wr(8'h04, 32'h0000_1000);
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'h0000_1000, 14'h0400, 10'h3FF, 1'b0);
    wait_done(tgt, 200);

    // Nothing changed: zero writes, DONE at t+3, READY at t+4
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'h0000_1000, 14'h0400, 10'h3FF, 1'b0);
    wait_done(tgt, 50);
    chk("zero_change_done_latency", 64'(done_cyc - start_cyc), 64'd3);
    while (cyc < start_cyc + 4) @(negedge CLK);
    chk("zero_change_ready_t4", 64'(READY), 64'd1);

    // Same inputs with FORCE: full rewrite
    push_full(32'h0000_1000, 14'h0400, 10'h3FF);
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'h0000_1000, 14'h0400, 10'h3FF, 1'b1);
    wait_done(tgt, 400);

    // Timeout with BUSY stuck low right after reset
    pulse_reset();
    bfm_en = 1'b0;
    push_wr(8'h00, 32'h0000_0010);
    push_done(1'b1);
    tgt = done_cnt + 1;
    issue(32'h0000_2000, 14'h0400, 10'h3FF, 1'b0);
    wait_done(tgt, TO + 200);
    lat = done_cyc - start_cyc;
    chk("timeout_latency_window", 64'(lat >= int'(TO) + 2 && lat <= int'(TO) + 5), 64'd1);
    chk("timeout_tr_low", 64'(spi.SPI_TR), 64'd0);
    repeat (2) @(negedge CLK);
    chk("err_sticky", 64'(ERR), 64'd1);
    bfm_en = 1'b1;

    // Next START clears ERR and rewrites everything (shadows never validated)
    push_full(32'h0000_2000, 14'h0400, 10'h3FF);
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'h0000_2000, 14'h0400, 10'h3FF, 1'b0);
    chk("err_cleared_on_start", 64'(ERR), 64'd0);
    wait_done(tgt, 400);

    // Reset during the CTW0 write
    push_wr(8'h00, 32'h0000_0010);
    push_wr(8'h03, 32'h0000_0300);
    push_wr(8'h04, 32'h0000_2000);
    n = ctw_cnt;
    issue(32'h0000_2000, 14'h0400, 10'h3FF, 1'b1);
    tgt = 0;
    while (ctw_cnt == n && tgt < 300) begin
      @(negedge CLK);
      tgt++;
    end
    chk("ctw0_write_reached", 64'(ctw_cnt - n), 64'd1);
    pulse_reset();
    chk("queue_empty_after_reset", 64'(exp_q.size()), 64'd0);

    // After reset the same request performs a full write again
    push_full(32'h0000_2000, 14'h0400, 10'h3FF);
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'h0000_2000, 14'h0400, 10'h3FF, 1'b0);
    wait_done(tgt, 400);

    // START pulses while a write is in flight are ignored
    push_wr(8'h04, 32'hABCD_0123);
    push_wr(8'h06, 32'h0000_1155);
    push_done(1'b0);
    tgt = done_cnt + 1;
    issue(32'hABCD_0123, 14'h0400, 10'h155, 1'b0);
    n = 0;
    while (!spi.SPI_BUSY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("busy_seen", 64'(spi.SPI_BUSY), 64'd1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(tgt, 200);
    repeat (20) @(negedge CLK);
    chk("single_done", 64'(done_cnt), 64'(tgt));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
